rv32_fetch_unit: RTL and testbench

//  Instruction fetch stage feeding rv32im_decoder_and_cu. Issues in-order word fetches to instruction memory over a req/gnt/rvalid bus.

---
 rtl/rv32_fetch_pkg.sv | 20 ++
 rtl/rv32_fetch_fifo.sv | 76 +++++++
 rtl/rv32_fetch_unit.sv | 106 ++++++++++
 tb/tb_rv32_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the rv32 instruction fetch stage.
package rv32_fetch_pkg;

  localparam int unsigned API_DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH     = 32;

  localparam logic [API_DATA_WIDTH-1:0] RV32_NOP      = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0]     RV32_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RESET_S = 1'b0,
    RUN_S   = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     pc;
    logic [API_DATA_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with a registered head/valid output stage.
module rv32_fetch_fifo
  import rv32_fetch_pkg::*;
#(
  parameter int unsigned           DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = RV32_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  fetch_entry_t   head_q, head_d;
  logic           valid_q, valid_d;
  logic           empty, full, do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // Next head is either the entry at the new read pointer or the word written into an empty slot.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    valid_d      = (count_d != '0);
    head_d       = head_q;
    head_d.instr = RV32_NOP;
    if (valid_d) begin
      head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wdata : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '{pc: RESET_PC, instr: RV32_NOP};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign head  = head_q;
  assign valid = valid_q;
  assign count = count_q;

endmodule

// File: rtl/rv32_fetch_unit.sv
// Instruction fetch stage: credit-limited in-order word fetch, prefetch buffering, redirect with response drop.
module rv32_fetch_unit
  import rv32_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RV32_RESET_PC,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      imem_req_o,
  output logic [ADDR_WIDTH-1:0]     imem_addr_o,
  input  logic                      imem_gnt_i,
  input  logic                      imem_rvalid_i,
  input  logic [API_DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                      redirect_i,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc_i,
  output logic                      instr_valid_o,
  input  logic                      instr_ready_i,
  output logic [API_DATA_WIDTH-1:0] instruction_o,
  output logic [ADDR_WIDTH-1:0]     instr_pc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]           outst_q, outst_d, drop_q, drop_d, fifo_count;
  logic [SW-1:0]           credit_sum;
  logic                    req_q, req_d;
  logic                    fire, rsp, rsp_drop, push, pop;
  fetch_entry_t            fifo_wdata, fifo_head;
  logic                    fifo_valid;

  assign fire       = req_q & imem_gnt_i;
  assign rsp        = imem_rvalid_i & (outst_q != '0);
  assign rsp_drop   = rsp & (drop_q != '0);
  assign push       = rsp & ~rsp_drop & ~redirect_i;
  assign pop        = fifo_valid & instr_ready_i & ~redirect_i;
  assign fifo_wdata = '{pc: rsp_pc_q, instr: imem_rdata_i};
  assign credit_sum = SW'(fifo_count) + SW'(outst_q) + SW'(fire);

  // Next-state: FSM, fetch PC, response PC, credit and drop accounting; redirect overrides all.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q + CW'(fire) - CW'(rsp);
    drop_d   = drop_q - CW'(rsp_drop);
    req_d    = 1'b0;
    case (state_q)
      RESET_S: state_d = RUN_S;
      RUN_S:   state_d = RUN_S;
      default: state_d = RESET_S;
    endcase
    if (fire) pc_d = pc_q + 32'd4;
    if (push) rsp_pc_d = rsp_pc_q + 32'd4;
    req_d = (credit_sum < SW'(FIFO_DEPTH));
    if (redirect_i) begin
      pc_d     = redirect_pc_i & ~32'h3;
      rsp_pc_d = redirect_pc_i & ~32'h3;
      drop_d   = outst_d;
      req_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RESET_S;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      req_q    <= req_d;
    end
  end

  rv32_fetch_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .flush (redirect_i),
    .head  (fifo_head),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = fifo_valid;
  assign instruction_o = fifo_head.instr;
  assign instr_pc_o    = fifo_head.pc;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed bench for rv32_fetch_unit with an in-order memory model returning ~addr as the instruction word.
module tb_rv32_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, instr_valid, instr_ready;
  logic [31:0] redirect_pc, instruction, instr_pc;
  logic        rsp_en;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_iss;
  logic [31:0] a0;
  logic [31:0] bus_q[$];
  logic [31:0] issued[$];
  logic [31:0] got[$];

  always #5 clk = ~clk;

  rv32_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instruction_o (instruction),
    .instr_pc_o    (instr_pc)
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_update();
    imem_rvalid = rst_n && rsp_en && (bus_q.size() > 0);
    imem_rdata  = (bus_q.size() > 0) ? ~bus_q[0] : 32'h0;
  endtask

  // One clock: log grants and decoder transfers seen before the edge, then advance the memory model.
  task automatic tick();
    logic        fire, rv, take;
    logic [31:0] a, ipc, iw;
    fire = rst_n & imem_req & imem_gnt;
    a    = imem_addr;
    rv   = imem_rvalid;
    take = rst_n & instr_valid & instr_ready & ~redirect;
    ipc  = instr_pc;
    iw   = instruction;
    @(posedge clk);
    if (rv) bus_q.delete(0);
    if (fire) begin
      bus_q.push_back(a);
      issued.push_back(a);
    end
    if (take) begin
      got.push_back(ipc);
      check32("payload", iw, ~ipc);
    end
    #1;
    bus_update();
  endtask

  task automatic check_reset(input string pfx);
    check32({pfx, "_req"},   {31'b0, imem_req},    32'h0);
    check32({pfx, "_addr"},  imem_addr,            32'h0);
    check32({pfx, "_valid"}, {31'b0, instr_valid}, 32'h0);
    check32({pfx, "_instr"}, instruction,          32'h0000_0013);
    check32({pfx, "_pc"},    instr_pc,             32'h0);
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0; rsp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");

    // Streaming: gnt=1, one-cycle response, ready=1
    rst_n = 1'b1; imem_gnt = 1'b1; rsp_en = 1'b1; instr_ready = 1'b1;
    tick();
    check32("first_req",  {31'b0, imem_req}, 32'h1);
    check32("first_addr", imem_addr,         32'h0);
    repeat (9) tick();
    check32("stream_cnt", 32'(got.size()), 32'd7);
    for (int i = 0; i < 6; i++) begin
      check32("stream_addr", issued[i], 32'(4 * i));
      check32("stream_pc",   got[i],    32'(4 * i));
    end

    // Decoder stalled: exactly FIFO_DEPTH words held, request withdrawn
    instr_ready = 1'b0;
    repeat (12) tick();
    check32("full_words", 32'(issued.size() - got.size()), 32'd4);
    check32("full_req",   {31'b0, imem_req},    32'h0);
    check32("full_valid", {31'b0, instr_valid}, 32'h1);
    check32("full_head",  instr_pc,             32'(4 * got.size()));
    instr_ready = 1'b1;
    repeat (16) tick();
    for (int i = 0; i < got.size(); i++) check32("resume_order", got[i], 32'(4 * i));

    // Grant stall: request and address held stable
    imem_gnt = 1'b0;
    a0    = imem_addr;
    n_iss = issued.size();
    check32("stall_req0", {31'b0, imem_req}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check32("stall_req",  {31'b0, imem_req}, 32'h1);
      check32("stall_addr", imem_addr,         a0);
    end
    check32("stall_iss", 32'(issued.size()), 32'(n_iss));
    repeat (4) tick();
    for (int i = 0; i < got.size(); i++) check32("stall_order", got[i], 32'(4 * i));

    // Two requests in flight, then redirect to an unaligned PC
    rsp_en = 1'b0; bus_update();
    imem_gnt = 1'b1;
    repeat (2) tick();
    check32("r1_outst", 32'(issued.size()), 32'(n_iss + 2));
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    check32("r1_addr", imem_addr, 32'h0000_0100);
    got.delete();
    imem_gnt = 1'b1; rsp_en = 1'b1; bus_update();
    repeat (10) tick();
    check32("r1_pc0", got[0], 32'h0000_0100);
    check32("r1_pc1", got[1], 32'h0000_0104);

    // Redirect coincident with a grant and a response
    repeat (4) tick();
    check32("r2_coinc", {30'b0, imem_req, imem_rvalid}, 32'h3);
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    got.delete();
    repeat (10) tick();
    check32("r2_pc0", got[0], 32'h0000_0200);
    check32("r2_pc1", got[1], 32'h0000_0204);
    check32("r2_pc2", got[2], 32'h0000_0208);

    // Address wrap at the top of the address space
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    got.delete();
    repeat (10) tick();
    check32("wrap_pc0", got[0], 32'hFFFF_FFF8);
    check32("wrap_pc1", got[1], 32'hFFFF_FFFC);
    check32("wrap_pc2", got[2], 32'h0000_0000);
    check32("wrap_pc3", got[3], 32'h0000_0004);

    // Reset asserted mid-stream: outputs return to reset values immediately
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    bus_q.delete(); issued.delete(); got.delete();
    bus_update();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check32("rerun_req",  {31'b0, imem_req}, 32'h1);
    check32("rerun_addr", imem_addr,         32'h0);
    repeat (8) tick();
    check32("rerun_pc0", got[0], 32'h0);
    check32("rerun_pc1", got[1], 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
